// File: rtl/inst_buffer_pkg.sv
// inst_buffer_pkg
//   Shared definitions for the instruction buffer slice: superscalar width N,
//   count width, the INST_PACKET layout, and a small clamp helper used to
//   limit push/pop requests to what the buffer can actually honour.
package inst_buffer_pkg;

  // Superscalar width: max pushes and pops per cycle.
  localparam int N  = 3;
  // Width of any 0..N count (num_in, num_dispatch, ib_open, num_valid).
  localparam int CW = $clog2(N + 1);

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] inst;
  } INST_PACKET;

  // min(req, lim) on 0..N counts.
  function automatic logic [CW-1:0] clamp_cnt(input logic [CW-1:0] req,
                                              input logic [CW-1:0] lim);
    return (req > lim) ? lim : req;
  endfunction

endpackage

// File: rtl/inst_buffer_if.sv
// inst_buffer_if
//   Fetch/dispatch-facing bundle of the instruction buffer.
//   master : the fetch + dispatch side (drives pushes, pops, squash)
//   slave  : the buffer itself
//   Signals
//     squash        flush all entries at next edge
//     in_insts      fetched packets, slots 0..num_in-1 meaningful
//     num_in        packets pushed this cycle
//     num_dispatch  head entries consumed this cycle
//     out_insts     head..head+N-1, oldest in slot 0
//     ib_open       free slots fetch may push, min(N, DEPTH-count)
//     num_valid     min(N, count)
//     full / empty  count == DEPTH / count == 0
import inst_buffer_pkg::*;

interface inst_buffer_if;
  logic                squash;
  INST_PACKET [N-1:0]  in_insts;
  logic [CW-1:0]       num_in;
  logic [CW-1:0]       num_dispatch;
  INST_PACKET [N-1:0]  out_insts;
  logic [CW-1:0]       ib_open;
  logic [CW-1:0]       num_valid;
  logic                full;
  logic                empty;

  modport master (
    output squash, in_insts, num_in, num_dispatch,
    input  out_insts, ib_open, num_valid, full, empty
  );

  modport slave (
    input  squash, in_insts, num_in, num_dispatch,
    output out_insts, ib_open, num_valid, full, empty
  );
endinterface

// File: rtl/inst_buffer.sv
// inst_buffer
//   Circular instruction queue between fetch and dispatch. Accepts up to N
//   packets per cycle, presents the oldest up to N in program order, and
//   retires num_dispatch head entries per cycle. squash empties the queue.
//   All outputs depend on registered state only (no path from num_in,
//   num_dispatch or squash to any output).
//   Ports
//     clock  system clock
//     reset  synchronous, active-high; priority over squash
//     ib     inst_buffer_if.slave bundle
//   Parameter
//     DEPTH  entry count, power of two, DEPTH >= 2*N
import inst_buffer_pkg::*;

module inst_buffer #(
  parameter int DEPTH = 16
) (
  input  logic          clock,
  input  logic          reset,
  inst_buffer_if.slave  ib
);

  localparam int PW   = $clog2(DEPTH);
  localparam int CNTW = $clog2(DEPTH + 1);
  localparam int CNW1 = CNTW + 1;

  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic [CNTW-1:0] count;
  INST_PACKET      mem [DEPTH];

  logic [PW-1:0]   ridx [N];
  logic [PW-1:0]   widx [N];
  logic [CNTW-1:0] space;
  logic [CW-1:0]   push_n;
  logic [CW-1:0]   pop_n;
  logic [CNW1-1:0] count_next;

  // Free-space and occupancy views, from registered count only.
  assign space = CNTW'(DEPTH) - count;

  always_comb begin
    ib.ib_open   = (space >= CNTW'(N)) ? CW'(N) : space[CW-1:0];
    ib.num_valid = (count >= CNTW'(N)) ? CW'(N) : count[CW-1:0];
    ib.full      = (count == CNTW'(DEPTH));
    ib.empty     = (count == '0);
  end

  // Read window: slots wrap naturally because ridx is PW bits wide.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      ridx[i] = head + PW'(i);
    end
  end

  always_comb begin
    for (int i = 0; i < N; i++) begin
      if (CNTW'(i) < count) begin
        ib.out_insts[i]       = mem[ridx[i]];
        ib.out_insts[i].valid = 1'b1;
      end else begin
        ib.out_insts[i] = '0;
      end
    end
  end

  // Write window.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      widx[i] = tail + PW'(i);
    end
  end

  // Over-limit requests are clamped. Push space is judged on the pre-pop
  // count, so a same-cycle pop never widens this cycle's push allowance.
  always_comb begin
    push_n     = clamp_cnt(ib.num_in, ib.ib_open);
    pop_n      = clamp_cnt(ib.num_dispatch, ib.num_valid);
    count_next = {1'b0, count} + CNW1'(push_n) - CNW1'(pop_n);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int e = 0; e < DEPTH; e++) begin
        mem[e].valid <= 1'b0;
      end
    end else if (ib.squash) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (CW'(i) < push_n) begin
          mem[widx[i]] <= ib.in_insts[i];
        end
      end
      tail  <= tail + PW'(push_n);
      // Popped entries are left in place; validity comes from count.
      head  <= head + PW'(pop_n);
      count <= count_next[CNTW-1:0];
    end
  end

`ifdef DEBUG
  always_ff @(posedge clock) begin
    if (!reset && !ib.squash) begin
      assert (ib.num_in <= ib.ib_open)
        else $error("inst_buffer: num_in %0d exceeds ib_open %0d", ib.num_in, ib.ib_open);
      assert (ib.num_dispatch <= ib.num_valid)
        else $error("inst_buffer: num_dispatch %0d exceeds num_valid %0d",
                    ib.num_dispatch, ib.num_valid);
    end
  end
`endif

endmodule

// File: tb/tb_inst_buffer.sv
import inst_buffer_pkg::*;

module tb_inst_buffer;

  localparam int DEPTH = 8;

  logic clock;
  logic reset;

  inst_buffer_if ib ();

  inst_buffer #(.DEPTH(DEPTH)) dut (
    .clock (clock),
    .reset (reset),
    .ib    (ib.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int compared   = 0;
  int mismatched = 0;
  bit check_en   = 1'b0;

  // Reference: the buffer contents as a plain program-order queue.
  INST_PACKET q [$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // Every-cycle comparison against the queue model, away from the active edge.
  always @(negedge clock) begin
    if (check_en) begin
      INST_PACKET e;
      for (int i = 0; i < N; i++) begin
        if (i < q.size()) begin
          e       = q[i];
          e.valid = 1'b1;
        end else begin
          e = '0;
        end
        chk($sformatf("out_insts[%0d]", i), 128'(ib.out_insts[i]), 128'(e));
      end
      chk("ib_open",   128'(ib.ib_open),   128'(imin(N, DEPTH - q.size())));
      chk("num_valid", 128'(ib.num_valid), 128'(imin(N, q.size())));
      chk("full",      128'(ib.full),      128'(q.size() == DEPTH));
      chk("empty",     128'(ib.empty),     128'(q.size() == 0));
    end
  end

  // One clock of stimulus; model is advanced just after the edge.
  task automatic cyc(input int nin, input int nd, input bit sq, input bit rs,
                     input logic [31:0] pc0);
    INST_PACKET pk [N];
    int open, avail, p, d;
    for (int i = 0; i < N; i++) begin
      pk[i].valid = 1'($urandom);
      pk[i].pc    = pc0 + 32'(4 * i);
      pk[i].inst  = $urandom;
      ib.in_insts[i] = pk[i];
    end
    ib.num_in       = CW'(nin);
    ib.num_dispatch = CW'(nd);
    ib.squash       = sq;
    reset           = rs;
    @(posedge clock);
    #1;
    if (rs || sq) begin
      q.delete();
    end else begin
      open  = imin(N, DEPTH - q.size());
      avail = imin(N, q.size());
      p     = imin(nin, open);
      d     = imin(nd, avail);
      for (int i = 0; i < d; i++) void'(q.pop_front());
      for (int i = 0; i < p; i++) q.push_back(pk[i]);
    end
  endtask

  logic [31:0] pc;
  int nin, nd;
  bit sq, rs;

  initial begin
    reset = 1'b1;
    ib.squash = 1'b0;
    ib.num_in = '0;
    ib.num_dispatch = '0;
    ib.in_insts = '0;

    // 1. reset then idle
    cyc(0, 0, 0, 1, 32'h0);
    check_en = 1'b1;
    cyc(0, 0, 0, 1, 32'h0);
    cyc(0, 0, 0, 0, 32'h0);
    chk("t1 ib_open", 128'(ib.ib_open), 128'(3));
    chk("t1 num_valid", 128'(ib.num_valid), 128'(0));
    chk("t1 empty", 128'(ib.empty), 128'(1));
    chk("t1 full", 128'(ib.full), 128'(0));
    chk("t1 valids", 128'({ib.out_insts[2].valid, ib.out_insts[1].valid, ib.out_insts[0].valid}), 128'(0));

    // 2. push 3, then pop 2 while pushing 1
    cyc(3, 0, 0, 0, 32'h0);
    chk("t2 num_valid", 128'(ib.num_valid), 128'(3));
    chk("t2 pc0", 128'(ib.out_insts[0].pc), 128'(32'h0));
    chk("t2 pc1", 128'(ib.out_insts[1].pc), 128'(32'h4));
    chk("t2 pc2", 128'(ib.out_insts[2].pc), 128'(32'h8));
    cyc(1, 2, 0, 0, 32'hC);
    chk("t2b pc0", 128'(ib.out_insts[0].pc), 128'(32'h8));
    chk("t2b pc1", 128'(ib.out_insts[1].pc), 128'(32'hC));
    chk("t2b slot2 valid", 128'(ib.out_insts[2].valid), 128'(0));
    chk("t2b num_valid", 128'(ib.num_valid), 128'(2));
    chk("t2b model size", 128'(q.size()), 128'(2));

    // 3. fill to 8 from empty, then a push while full is ignored
    cyc(0, 0, 0, 1, 32'h0);
    cyc(3, 0, 0, 0, 32'h100);
    cyc(3, 0, 0, 0, 32'h10C);
    cyc(2, 0, 0, 0, 32'h118);
    chk("t3 full", 128'(ib.full), 128'(1));
    chk("t3 ib_open", 128'(ib.ib_open), 128'(0));
    cyc(1, 0, 0, 0, 32'h200);
    chk("t3b full", 128'(ib.full), 128'(1));
    chk("t3b model size", 128'(q.size()), 128'(8));
    chk("t3b pc0", 128'(ib.out_insts[0].pc), 128'(32'h100));

    // 4. wrap: drain 3, then push/pop 3 per cycle for 6 cycles
    cyc(0, 3, 0, 0, 32'h0);
    chk("t4 head pc", 128'(ib.out_insts[0].pc), 128'(32'h10C));
    pc = 32'h300;
    for (int k = 0; k < 6; k++) begin
      cyc(3, 3, 0, 0, pc);
      pc += 32'd12;
    end
    chk("t4 wrap pc0", 128'(ib.out_insts[0].pc), 128'(32'h334));
    chk("t4 wrap pc2", 128'(ib.out_insts[2].pc), 128'(32'h33C));

    // 5. squash at count 5 with simultaneous push 3 / pop 2
    cyc(3, 2, 1, 0, 32'h400);
    chk("t5 empty", 128'(ib.empty), 128'(1));
    chk("t5 ib_open", 128'(ib.ib_open), 128'(3));
    chk("t5 valids", 128'({ib.out_insts[2].valid, ib.out_insts[1].valid, ib.out_insts[0].valid}), 128'(0));

    // 6. reset mid-stream with squash at count 6, then push
    cyc(3, 0, 0, 0, 32'h450);
    cyc(3, 0, 0, 0, 32'h45C);
    chk("t6 model size", 128'(q.size()), 128'(6));
    cyc(3, 0, 1, 1, 32'h480);
    chk("t6 empty", 128'(ib.empty), 128'(1));
    chk("t6 ib_open", 128'(ib.ib_open), 128'(3));
    chk("t6 num_valid", 128'(ib.num_valid), 128'(0));
    cyc(2, 0, 0, 0, 32'h500);
    chk("t6b pc0", 128'(ib.out_insts[0].pc), 128'(32'h500));
    chk("t6b pc1", 128'(ib.out_insts[1].pc), 128'(32'h504));
    chk("t6b num_valid", 128'(ib.num_valid), 128'(2));

    // Random traffic, including over-limit requests that must clamp.
    pc = 32'h1000;
    for (int k = 0; k < 3000; k++) begin
      nin = $urandom_range(0, N);
      nd  = $urandom_range(0, N);
      sq  = ($urandom_range(0, 39) == 0);
      rs  = ($urandom_range(0, 149) == 0);
      cyc(nin, nd, sq, rs, pc);
      pc += 32'd12;
    end

    cyc(0, 0, 0, 0, 32'h0);
    check_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/inst_buffer.md
Name: inst_buffer

Overview:
Circular instruction queue between fetch and dispatch.
- Accepts up to N fetched INST_PACKETs per cycle from fetch.
- Presents the oldest up to N entries, in program order, to dispatch.
- Retires the head entries each cycle according to dispatch's num_dispatch count.
- squash (branch mispredict / recovery) empties the queue.

Parameters:
N, `N, superscalar width; max pushes and pops per cycle.
DEPTH, 16, entry count; power of two, DEPTH >= 2*N.

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
squash  input  1  flush all entries at next edge
in_insts  input  INST_PACKET[N-1:0]  fetched instructions, compacted: slots 0..num_in-1 are meaningful
num_in  input  $clog2(N+1)  number of instructions fetch pushes this cycle
num_dispatch  input  $clog2(N+1)  number of head entries dispatch consumed this cycle
out_insts  output  INST_PACKET[N-1:0]  head..head+N-1, oldest in slot 0
ib_open  output  $clog2(N+1)  free slots fetch may push this cycle, min(N, DEPTH-count)
num_valid  output  $clog2(N+1)  min(N, count); number of valid out_insts slots
full  output  1  count == DEPTH
empty  output  1  count == 0

Behaviour:
State
- head and tail are $clog2(DEPTH)-bit pointers.
- count is $clog2(DEPTH+1) bits.
- Storage is DEPTH x INST_PACKET.

Reset
- At a rising edge with reset=1: head=tail=count=0 and every entry's valid=0.
- After reset: out_insts[*].valid=0, ib_open=N, num_valid=0, empty=1, full=0.

Outputs
- All outputs are combinational from registered state only.
- No combinational path exists from num_in, num_dispatch or squash to any output (avoids a loop with dispatch).
- out_insts[i] = mem[(head+i) mod DEPTH] with valid forced to 1 when i < count.
- out_insts[i] is all-zero with valid=0 when i >= count.

Push
- mem[(tail+i) mod DEPTH] <= in_insts[i] for i < num_in.
- tail advances by num_in, modulo DEPTH.
- Latency: a pushed instruction appears on out_insts at the cycle after the push.
- No same-cycle bypass to dispatch.

Pop
- head advances by num_dispatch, modulo DEPTH.
- Popped entries are not cleared; valid is derived from count.

Simultaneous push and pop
- count_next = count + num_in - num_dispatch, computed at $clog2(DEPTH+1)+1 bits.
- Push space is judged on the pre-pop count (ib_open). Same-cycle pops never enlarge that cycle's push allowance.

Protocol limits
- num_in <= ib_open and num_dispatch <= num_valid are required.
- On violation: clamp to the limit (push min(num_in, ib_open), pop min(num_dispatch, num_valid)).
- A violation also fires a simulation-only assertion under `DEBUG.

Squash
- At an edge with squash=1: head=tail=count=0, and that cycle's push and pop are discarded.
- reset has priority over squash.

Wrap-around
- Pointer arithmetic wraps mod DEPTH.
- Windows spanning DEPTH-1 -> 0 read and write correctly.

Full / empty
- full: ib_open=0 and all pushes are ignored.
- empty: num_valid=0 and all pops are ignored.

Decomposition:
- INST_PACKET and `N come from the shared sys_defs package.
- DEPTH stays a module parameter. Add IB_DEPTH to sys_defs only if the top level must agree with it.
- No sub-module is needed: pointer/count update plus N-wide read and write muxes fit in one module.
- Read and write index generation can be split into separate always_comb blocks for clarity.

Test Plan:
All scenarios use N=3, DEPTH=8.
1. Reset, then idle -> out_insts[0..2].valid=0, ib_open=3, num_valid=0, empty=1, full=0.
2. Push 3 (PCs 0x0,0x4,0x8), num_dispatch=0 -> next cycle num_valid=3 and out_insts PCs in order 0x0,0x4,0x8. Then pop 2 while pushing 1 (0xC) -> out_insts slots 0..1 show 0x8,0xC; slot 2 valid=0; count=2.
3. Fill to 8 (push 3,3,2) -> full=1, ib_open=0. A push of 1 that cycle is ignored and count stays 8.
4. Wrap: push/pop 3 per cycle for 6 cycles with incrementing PCs -> head crosses 7->0 and out_insts stays in strict PC order with no duplicates or gaps.
5. Squash with count=5 and simultaneous push 3 / pop 2 -> next cycle count=0, empty=1, all valid=0, ib_open=3.
6. Reset asserted mid-stream while squash=1 and count=6 -> next cycle identical to post-reset state. A push the following cycle lands at index 0.
